decode_regfile: RTL and testbench

Decode stage directly downstream of instruction fetch: takes the 32-bit RV32I `instruction` word fetch presents each cycle, splits it into fields, builds the sign-extended immediate, generates datapath control, and reads two operands from the 32×32 integer register file it owns. The write-back port from the end of the datapath updates the register file on the clock edge. A retired-instruction counter tracks every legal instruction decoded.

---
 rtl/decode_regfile.sv | 253 +++++++++++++++++++++++++
 tb/tb_decode_regfile.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile.sv
// decode_regfile
//   RV32I decode stage with an owned 32x32 integer register file.
//   The instruction from fetch is split into fields. The stage builds the
//   sign-extended immediate and the datapath control. Two operands are read
//   combinationally, with a write-through bypass from the write-back port.
//   It also counts every legal instruction that is decoded.
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   instruction[31:0]     instruction word from fetch, valid every cycle
//   wb_en/wb_addr/wb_data register write-back port
//   rs1_data, rs2_data    source operands
//   rd_addr               destination register field
//   imm                   sign-extended immediate
//   alu_op, alu_src       ALU operation and operand-B select
//   reg_write, mem_read, mem_write, branch, jump, illegal   control
//   instret               count of legal instructions decoded
module decode_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [4:0]  rd_addr,
  output logic [31:0] imm,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [31:0] regs_r [0:31];
  logic [31:0] instret_r;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic [4:0] rs1_addr_s;
  logic [4:0] rs2_addr_s;
  logic       wb_live_s;

  assign opcode_s   = instruction[6:0];
  assign funct3_s   = instruction[14:12];
  assign funct7_s   = instruction[31:25];
  assign rs1_addr_s = instruction[19:15];
  assign rs2_addr_s = instruction[24:20];
  assign rd_addr    = instruction[11:7];
  assign instret    = instret_r;
  // A write-back only counts when it targets a real register outside reset.
  assign wb_live_s  = rst_n && wb_en && (wb_addr != 5'd0);

  // Maps funct3 to the ALU op; alt selects SUB/SRA over ADD/SRL.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      3'd7:    op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Register file storage; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) begin
        regs_r[k] <= 32'd0;
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // Operand reads with same-cycle write-through bypass.
  always_comb begin
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    if (rs1_addr_s == 5'd0) begin
      rs1_data = 32'd0;
    end else if (wb_live_s && (wb_addr == rs1_addr_s)) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = regs_r[rs1_addr_s];
    end
    if (rs2_addr_s == 5'd0) begin
      rs2_data = 32'd0;
    end else if (wb_live_s && (wb_addr == rs2_addr_s)) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = regs_r[rs2_addr_s];
    end
  end

  // Immediate by instruction format; unknown opcodes use the I layout.
  always_comb begin
    imm = 32'd0;
    case (opcode_s)
      OP_R:            imm = 32'd0;
      OP_STORE:        imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OP_BRANCH:       imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                              instruction[30:25], instruction[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {instruction[31:12], 12'd0};
      OP_JAL:          imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                              instruction[20], instruction[30:21], 1'b0};
      default:         imm = {{20{instruction[31]}}, instruction[31:20]};
    endcase
  end

  // Control decode; an illegal encoding forces every control output low.
  always_comb begin
    logic       legal;
    logic [3:0] op;
    logic       src, rw, mr, mw, br, jp;
    legal = 1'b0;
    op    = ALU_ADD;
    src   = 1'b0;
    rw    = 1'b0;
    mr    = 1'b0;
    mw    = 1'b0;
    br    = 1'b0;
    jp    = 1'b0;
    case (opcode_s)
      OP_R: begin
        rw    = 1'b1;
        op    = alu_from_funct3(funct3_s, funct7_s == F7_ALT);
        legal = (funct7_s == F7_BASE) ||
                ((funct7_s == F7_ALT) && ((funct3_s == 3'd0) || (funct3_s == 3'd5)));
      end
      OP_IALU: begin
        rw  = 1'b1;
        src = 1'b1;
        // Only the shift-right form distinguishes funct7; ADDI never becomes SUB.
        op  = alu_from_funct3(funct3_s, (funct3_s == 3'd5) && (funct7_s == F7_ALT));
        if (funct3_s == 3'd1) begin
          legal = (funct7_s == F7_BASE);
        end else if (funct3_s == 3'd5) begin
          legal = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
        end else begin
          legal = 1'b1;
        end
      end
      OP_LOAD: begin
        rw    = 1'b1;
        mr    = 1'b1;
        src   = 1'b1;
        legal = (funct3_s != 3'd3) && (funct3_s != 3'd6) && (funct3_s != 3'd7);
      end
      OP_STORE: begin
        mw    = 1'b1;
        src   = 1'b1;
        legal = (funct3_s <= 3'd2);
      end
      OP_BRANCH: begin
        br    = 1'b1;
        op    = ALU_SUB;
        legal = (funct3_s != 3'd2) && (funct3_s != 3'd3);
      end
      OP_LUI: begin
        rw    = 1'b1;
        src   = 1'b1;
        op    = ALU_PASSB;
        legal = 1'b1;
      end
      OP_AUIPC: begin
        rw    = 1'b1;
        src   = 1'b1;
        legal = 1'b1;
      end
      OP_JAL: begin
        rw    = 1'b1;
        jp    = 1'b1;
        legal = 1'b1;
      end
      OP_JALR: begin
        rw    = 1'b1;
        jp    = 1'b1;
        src   = 1'b1;
        legal = (funct3_s == 3'd0);
      end
      default: legal = 1'b0;
    endcase

    if (legal) begin
      illegal   = 1'b0;
      alu_op    = op;
      alu_src   = src;
      reg_write = rw;
      mem_read  = mr;
      mem_write = mw;
      branch    = br;
      jump      = jp;
    end else begin
      illegal   = 1'b1;
      alu_op    = ALU_ADD;
      alu_src   = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= 32'd0;
    end else if (!illegal) begin
      instret_r <= instret_r + 32'd1;
    end else begin
      instret_r <= instret_r;
    end
  end

endmodule

// File: tb/tb_decode_regfile.sv
module tb_decode_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = 32'h0000_0013;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic [31:0] rs1_data, rs2_data, imm, instret;
  logic [4:0]  rd_addr;
  logic [3:0]  alu_op;
  logic        alu_src, reg_write, mem_read, mem_write, branch, jump, illegal;

  int total = 0;
  int bad = 0;

  decode_regfile dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr), .imm(imm),
    .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .jump(jump), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_regs [0:31];
  logic [31:0] m_instret;
  logic        preset_en = 1'b0;
  logic [31:0] preset_val = 32'd0;
  logic        cmp_on = 1'b0;
  int          base_op [0:7] = '{0, 2, 3, 4, 5, 6, 8, 9};

  // Returns {illegal, reg_write, mem_read, mem_write, branch, jump, alu_src, alu_op[3:0]}
  function automatic logic [10:0] exp_ctrl(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic legal, rw, mr, mw, br, jp, src;
    int alu;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    legal = 0; rw = 0; mr = 0; mw = 0; br = 0; jp = 0; src = 0; alu = 0;
    case (op)
      7'h33: begin
        rw = 1;
        if (f7 == 7'h00) begin legal = 1; alu = base_op[f3]; end
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin legal = 1; alu = base_op[f3] + 1; end
      end
      7'h13: begin
        rw = 1; src = 1;
        alu = base_op[f3] + ((f3 == 3'd5 && f7 == 7'h20) ? 1 : 0);
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
        else legal = 1;
      end
      7'h03: begin rw = 1; mr = 1; src = 1; legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
      7'h23: begin mw = 1; src = 1; legal = (f3 inside {3'd0, 3'd1, 3'd2}); end
      7'h63: begin br = 1; alu = 1; legal = !(f3 inside {3'd2, 3'd3}); end
      7'h37: begin rw = 1; src = 1; alu = 10; legal = 1; end
      7'h17: begin rw = 1; src = 1; legal = 1; end
      7'h6F: begin rw = 1; jp = 1; legal = 1; end
      7'h67: begin rw = 1; jp = 1; src = 1; legal = (f3 == 3'd0); end
      default: legal = 0;
    endcase
    if (!legal) return 11'h400;
    return {1'b0, rw, mr, mw, br, jp, src, 4'(alu)};
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] i, output logic known);
    logic [31:0] ival;
    ival = 32'($signed(i) >>> 20);
    known = 1'b1;
    case (i[6:0])
      7'h33:               return 32'd0;
      7'h13, 7'h03, 7'h67: return ival;
      7'h23:               return (ival & ~32'h1F) | {27'd0, i[11:7]};
      7'h63:               return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17:        return i & 32'hFFFF_F000;
      7'h6F:               return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: begin known = 1'b0; return 32'd0; end
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  logic [10:0] cur_ctrl;
  assign cur_ctrl = exp_ctrl(instruction);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) m_regs[k] <= 32'd0;
      m_instret <= 32'd0;
    end else begin
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] <= wb_data;
      m_instret <= (preset_en ? preset_val : m_instret) + (cur_ctrl[10] ? 32'd0 : 32'd1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      logic known;
      logic [31:0] ei;
      ei = exp_imm(instruction, known);
      chk("rs1_data", rs1_data, exp_read(instruction[19:15]));
      chk("rs2_data", rs2_data, exp_read(instruction[24:20]));
      chk("rd_addr", {27'd0, rd_addr}, {27'd0, instruction[11:7]});
      if (known) chk("imm", imm, ei);
      chk("ctrl", {21'd0, illegal, reg_write, mem_read, mem_write, branch, jump, alu_src, alu_op},
          {21'd0, cur_ctrl});
      chk("instret", instret, preset_en ? preset_val : (rst_n ? m_instret : 32'd0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [0:8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

  initial begin
    logic [31:0] saved;
    logic [31:0] r;
    #7 cmp_on = 1'b1;

    // Reset state with ADDI x0,x0,0; write attempts during reset are dropped.
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h1111_2222;
    next_cycle();
    chk("reset rs1", rs1_data, 32'd0);
    chk("reset rs2", rs2_data, 32'd0);
    chk("reset instret", instret, 32'd0);
    chk("reset illegal", {31'd0, illegal}, 32'd0);
    chk("reset reg_write", {31'd0, reg_write}, 32'd1);
    chk("reset alu_src", {31'd0, alu_src}, 32'd1);
    wb_en = 1'b0;
    next_cycle();
    rst_n = 1'b1;

    // Write x5 then read it on both ports.
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    next_cycle();
    wb_en = 1'b0; instruction = 32'h0052_8033;
    #2;
    chk("x5 rs1", rs1_data, 32'hDEAD_BEEF);
    chk("x5 rs2", rs2_data, 32'hDEAD_BEEF);
    chk("add alu_op", {28'd0, alu_op}, 32'd0);

    // x0 ignores writes.
    next_cycle();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_1234; instruction = 32'h0000_0033;
    next_cycle();
    wb_en = 1'b0;
    #2 chk("x0 read", rs1_data, 32'd0);

    // Same-cycle bypass on rs1=x7.
    next_cycle();
    instruction = 32'h0003_80B3; wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5_A5A5;
    #2 chk("bypass x7", rs1_data, 32'hA5A5_A5A5);

    // Branch and LUI immediates.
    next_cycle();
    wb_en = 1'b0; instruction = 32'hFE00_0EE3;
    #2;
    chk("beq imm", imm, 32'hFFFF_FFFC);
    chk("beq branch", {31'd0, branch}, 32'd1);
    chk("beq alu_op", {28'd0, alu_op}, 32'd1);
    chk("beq reg_write", {31'd0, reg_write}, 32'd0);
    next_cycle();
    instruction = 32'h1234_50B7;
    #2;
    chk("lui imm", imm, 32'h1234_5000);
    chk("lui alu_op", {28'd0, alu_op}, 32'd10);

    // Illegal word holds instret across three edges.
    next_cycle();
    instruction = 32'hFFFF_FFFF;
    saved = m_instret;
    #2 chk("ffff ctrl", {21'd0, illegal, reg_write, mem_read, mem_write, branch, jump, alu_src, alu_op}, 32'h400);
    repeat (3) next_cycle();
    chk("illegal instret hold", instret, saved);
    instruction = 32'h4000_1033;
    #2 chk("sll alt illegal", {31'd0, illegal}, 32'd1);

    // Counter wrap from 0xFFFFFFFE.
    next_cycle();
    instruction = 32'h0000_0013;
    preset_val = 32'hFFFF_FFFE;
    preset_en = 1'b1;
    force dut.instret_r = 32'hFFFF_FFFE;
    #2 chk("wrap preset", instret, 32'hFFFF_FFFE);
    @(negedge clk);
    #1 release dut.instret_r;
    next_cycle();
    preset_en = 1'b0;
    #2 chk("wrap edge1", instret, 32'hFFFF_FFFF);
    next_cycle();
    #2 chk("wrap edge2", instret, 32'h0000_0000);
    next_cycle();
    #2 chk("wrap edge3", instret, 32'h0000_0001);

    // Asynchronous reset mid-cycle.
    next_cycle();
    instruction = 32'h0002_8033;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst instret", instret, 32'd0);
    chk("async rst rs1", rs1_data, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    #2 chk("x5 cleared", rs1_data, 32'd0);

    // Randomised traffic, with occasional mid-cycle reset pulses.
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      rst_n = 1'b1;
      r = $urandom;
      r[6:0] = ($urandom_range(0, 9) < 9) ? ops[$urandom_range(0, 8)] : 7'($urandom);
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        default: r[31:25] = r[31:25];
      endcase
      instruction = r;
      wb_en = 1'($urandom);
      case ($urandom_range(0, 2))
        0: wb_addr = r[19:15];
        1: wb_addr = r[24:20];
        default: wb_addr = 5'($urandom);
      endcase
      wb_data = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
      end
    end

    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
